// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential add-shift multiplier.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/addshift_mult_seq_addsub_ext.sv
// (WIDTH+1)-bit adder/subtractor with sign- or zero-extension of both operands.
// Latency: combinational.
// Backpressure: not applicable.
//
// Ports:
//   a    WIDTH    accumulator operand
//   b    WIDTH    addend / subtrahend
//   sub  1        1: a - b, 0: a + b
//   sext 1        1: sign-extend operands, 0: zero-extend
//   sum  WIDTH+1  result; MSB is the new extension bit
module addsub_ext #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sext,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] a_e;
    logic [WIDTH:0] b_e;

    assign a_e = {sext & a[WIDTH-1], a};
    assign b_e = {sext & b[WIDTH-1], b};
    assign sum = sub ? (a_e - b_e) : (a_e + b_e);

endmodule

// File: rtl/addshift_mult_seq.sv
// Sequential add-shift multiplier: {Aval,Bval} = B * S, one add/sub + shift per cycle.
// Latency: Run sampled in IDLE at edge t, Done=1 after edge t+WIDTH.
// Backpressure: level handshake; result held in DONE until Run drops, no auto-repeat.
//
// Ports:
//   Clk, Reset  clock / asynchronous active-high reset
//   Din         operand bus: B on LoadB, S on start
//   LoadB       load Din into B (IDLE and DONE only; Run wins in IDLE)
//   Run         level start request
//   Aval, Bval  product high / low halves
//   X           extension bit of A
//   Busy, Done  registered status levels
//   Signed      (only with MULT_UNSIGNED_MODE_EN) 1: two's complement, 0: unsigned;
//               sampled at start
module addshift_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Din,
    input  logic             LoadB,
    input  logic             Run,
`ifdef MULT_UNSIGNED_MODE_EN
    input  logic             Signed,
`endif
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             x_q;
    logic             busy_q;
    logic             done_q;
    logic             sgn_mode;

`ifdef MULT_UNSIGNED_MODE_EN
    logic             sgn_q;
    assign sgn_mode = sgn_q;
`else
    assign sgn_mode = 1'b1;
`endif

    logic             last_step;
    logic [WIDTH-1:0] addend;
    logic             do_sub;
    logic [WIDTH:0]   sum;

    assign last_step = (cnt == CW'(WIDTH - 1));
    // A zero addend when B[0]=0 turns the step into a pure extend-and-shift.
    assign addend    = b_q[0] ? s_q : '0;
    // The multiplier MSB has negative weight in two's complement.
    assign do_sub    = sgn_mode & b_q[0] & last_step;

    addsub_ext #(.WIDTH(WIDTH)) u_addsub (
        .a    (a_q),
        .b    (addend),
        .sub  (do_sub),
        .sext (sgn_mode),
        .sum  (sum)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            x_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef MULT_UNSIGNED_MODE_EN
            sgn_q  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        s_q    <= Din;
                        a_q    <= '0;
                        x_q    <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= CALC;
`ifdef MULT_UNSIGNED_MODE_EN
                        sgn_q  <= Signed;
`endif
                    end else if (LoadB) begin
                        b_q <= Din;
                    end
                end
                CALC: begin
                    // {X,A,B} >> 1: the sum MSB enters A. Signed mode replicates
                    // it into X (arithmetic); unsigned mode shifts a zero into X.
                    a_q <= sum[WIDTH:1];
                    b_q <= {sum[0], b_q[WIDTH-1:1]};
                    x_q <= sgn_mode & sum[WIDTH];
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (LoadB) begin
                        b_q <= Din;
                    end
                    if (!Run) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule
